// File: rtl/stream_mux_pkg.sv
// Shared types for the N:1 packet-aware stream multiplexer.
package stream_mux_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid channel after i_ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         i_valid,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic [N-1:0]         o_grant_c,
   output logic [$clog2(N)-1:0] o_idx_c,
   output logic                 o_any_c
);

   localparam int unsigned IW = $clog2(N);

   always_comb begin
      o_grant_c = '0;
      o_idx_c   = '0;
      o_any_c   = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         int unsigned ch;
         ch = (32'(i_ptr) + k) % N;
         if (!o_any_c && i_valid[IW'(ch)]) begin
            o_any_c              = 1'b1;
            o_idx_c              = IW'(ch);
            o_grant_c[IW'(ch)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_n_1.sv
// N:1 stream multiplexer with packet locking, round-robin or fixed arbitration,
// and a single registered output stage running at one beat per cycle.
module stream_mux_n_1
   import stream_mux_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N-1:0]              in_valid,
   output logic [N-1:0]              in_ready,
   input  logic [N-1:0][WIDTH-1:0]   in_data,
   input  logic [N-1:0]              in_last,
   input  logic                      fixed_mode,
   input  logic [$clog2(N)-1:0]      fixed_sel,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_last,
   output logic [$clog2(N)-1:0]      out_ch
);

   localparam int unsigned IW = $clog2(N);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [IW-1:0]    r_lock_ch;
   logic [IW-1:0]    w_lock_ch_nxt;
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    w_ptr_nxt;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_last;
   logic [IW-1:0]    r_out_ch;

   logic             w_can_accept;
   logic [IW-1:0]    w_gidx;
   logic [N-1:0]     w_grant_vec;
   logic [N-1:0]     w_ready;
   logic             w_xfer;
   logic [N-1:0]     w_arb_grant;
   logic [IW-1:0]    w_arb_idx;
   logic             w_arb_any;

   rr_arbiter #(
      .N (N)
   ) u_rr_arbiter (
      .i_valid   (in_valid),
      .i_ptr     (r_ptr),
      .o_grant_c (w_arb_grant),
      .o_idx_c   (w_arb_idx),
      .o_any_c   (w_arb_any)
   );

   assign w_can_accept = !r_out_valid || out_ready;

   // Grant selection: a locked packet owns the mux; otherwise arbitrate by mode.
   always_comb begin
      w_gidx      = r_lock_ch;
      w_grant_vec = '0;
      if (r_state == ST_LOCKED) begin
         w_gidx                 = r_lock_ch;
         w_grant_vec[r_lock_ch] = 1'b1;
      end else if (fixed_mode) begin
         w_gidx                 = fixed_sel;
         w_grant_vec[fixed_sel] = 1'b1;
      end else begin
         w_gidx      = w_arb_idx;
         w_grant_vec = w_arb_any ? w_arb_grant : '0;
      end
      w_ready = (w_can_accept && !rst) ? w_grant_vec : '0;
   end

   assign w_xfer   = |(w_ready & in_valid);
   assign in_ready = w_ready;

   // Packet lock FSM and round-robin pointer next state.
   always_comb begin
      w_state_nxt   = r_state;
      w_lock_ch_nxt = r_lock_ch;
      w_ptr_nxt     = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               w_ptr_nxt = w_gidx;
               if (!in_last[w_gidx]) begin
                  w_state_nxt   = ST_LOCKED;
                  w_lock_ch_nxt = w_gidx;
               end
            end
         end
         ST_LOCKED: begin
            if (w_xfer && in_last[w_gidx]) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_lock_ch <= '0;
         r_ptr     <= IW'(N - 1);
      end else begin
         r_state   <= w_state_nxt;
         r_lock_ch <= w_lock_ch_nxt;
         r_ptr     <= w_ptr_nxt;
      end
   end

   // Output stage: loads whenever it is empty or being drained this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_ch    <= '0;
      end else if (w_can_accept) begin
         r_out_valid <= w_xfer;
         if (w_xfer) begin
            r_out_data <= in_data[w_gidx];
            r_out_last <= in_last[w_gidx];
            r_out_ch   <= w_gidx;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Bench for stream_mux_n_1: directed vector table, corner sequences, and random traffic vs a reference model.
module tb_stream_mux_n_1;

   localparam int N = 4;
   localparam int W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      in_valid;
   logic [N-1:0]      in_ready;
   logic [N-1:0][W-1:0] in_data;
   logic [N-1:0]      in_last;
   logic              fixed_mode;
   logic [1:0]        fixed_sel;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic              out_last;
   logic [1:0]        out_ch;

   stream_mux_n_1 #(.N(N), .WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .fixed_mode (fixed_mode),
      .fixed_sel  (fixed_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ch     (out_ch)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit               rst;
      logic [3:0]       valid;
      logic [3:0]       last;
      logic [3:0][3:0]  data;
      bit               fm;
      logic [1:0]       fs;
      bit               ordy;
      logic [3:0]       e_ready;
      bit               e_ov;
      logic [3:0]       e_od;
      logic [1:0]       e_ch;
   } vec_t;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: packet owner, last winner, and contents of the output slot.
   int m_ptr;
   bit m_locked;
   int m_lock;
   bit m_ov;
   int m_od;
   bit m_ol;
   int m_och;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr    = N - 1;
      m_locked = 0;
      m_lock   = 0;
      m_ov     = 0;
      m_od     = 0;
      m_ol     = 0;
      m_och    = 0;
   endtask

   function automatic int model_grant(input vec_t v);
      if (m_locked) return m_lock;
      if (v.fm) return int'(v.fs);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (v.valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic vec_t mk(input bit r, input logic [3:0] valid, input logic [3:0] last,
                               input logic [15:0] data, input bit fm, input logic [1:0] fs,
                               input bit ordy, input logic [3:0] e_ready, input bit e_ov,
                               input logic [3:0] e_od, input logic [1:0] e_ch);
      vec_t v;
      v.rst = r; v.valid = valid; v.last = last; v.data = data;
      v.fm = fm; v.fs = fs; v.ordy = ordy;
      v.e_ready = e_ready; v.e_ov = e_ov; v.e_od = e_od; v.e_ch = e_ch;
      return v;
   endfunction

   // One clock: drive, compare mid-cycle (table or model), then advance the model.
   task automatic run(input vec_t v, input bit use_tab, input string tag);
      int         g;
      bit         can;
      bit         xfer;
      logic [3:0] exp_ready;
      rst        = v.rst;
      in_valid   = v.valid;
      in_last    = v.last;
      in_data    = v.data;
      fixed_mode = v.fm;
      fixed_sel  = v.fs;
      out_ready  = v.ordy;
      @(negedge clk);
      g   = model_grant(v);
      can = !m_ov || v.ordy;
      exp_ready = (!v.rst && can && g >= 0) ? 4'(1 << g) : 4'b0000;
      if (use_tab) begin
         check({tag, " in_ready"}, 32'(in_ready), 32'(v.e_ready));
         if (!v.rst) begin
            check({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
            if (v.e_ov) begin
               check({tag, " out_data"}, 32'(out_data), 32'(v.e_od));
               check({tag, " out_ch"}, 32'(out_ch), 32'(v.e_ch));
            end
         end
      end else begin
         check({tag, " in_ready"}, 32'(in_ready), 32'(exp_ready));
         check({tag, " out_valid"}, 32'(out_valid), 32'(m_ov));
         if (m_ov) begin
            check({tag, " out_data"}, 32'(out_data), 32'(m_od));
            check({tag, " out_last"}, 32'(out_last), 32'(m_ol));
            check({tag, " out_ch"}, 32'(out_ch), 32'(m_och));
         end
      end
      if (v.rst) begin
         model_reset();
      end else begin
         xfer = (exp_ready != 4'b0000) && v.valid[2'(g)];
         if (can) begin
            m_ov = xfer;
            if (xfer) begin
               m_od  = int'(v.data[2'(g)]);
               m_ol  = v.last[2'(g)];
               m_och = g;
            end
         end
         if (xfer) begin
            if (!m_locked) begin
               m_ptr = g;
               if (!v.last[2'(g)]) begin
                  m_locked = 1;
                  m_lock   = g;
               end
            end else if (v.last[2'(g)]) begin
               m_locked = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tab[$];
   vec_t v;

   initial begin
      rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0;
      fixed_mode = 1'b0; fixed_sel = '0; out_ready = 1'b1;
      model_reset();
      @(posedge clk);
      #1;

      // Round-robin over four single-beat channels
      tab.push_back(mk(1, 4'hf, 4'hf, 16'hdcba, 0, 0, 1, 4'b0000, 0, 0, 0));
      tab.push_back(mk(0, 4'hf, 4'hf, 16'hdcba, 0, 0, 1, 4'b0001, 0, 0, 0));
      tab.push_back(mk(0, 4'hf, 4'hf, 16'hdcba, 0, 0, 1, 4'b0010, 1, 4'ha, 0));
      tab.push_back(mk(0, 4'hf, 4'hf, 16'hdcba, 0, 0, 1, 4'b0100, 1, 4'hb, 1));
      tab.push_back(mk(0, 4'hf, 4'hf, 16'hdcba, 0, 0, 1, 4'b1000, 1, 4'hc, 2));
      tab.push_back(mk(0, 4'hf, 4'hf, 16'hdcba, 0, 0, 1, 4'b0001, 1, 4'hd, 3));
      tab.push_back(mk(0, 4'hf, 4'hf, 16'hdcba, 0, 0, 1, 4'b0010, 1, 4'ha, 0));
      // Ch1 three-beat packet stays contiguous while ch0/ch2 wait
      tab.push_back(mk(1, 4'h0, 4'hf, 16'h0000, 0, 0, 1, 4'b0000, 0, 0, 0));
      tab.push_back(mk(0, 4'b0001, 4'hf, 16'h0000, 0, 0, 1, 4'b0001, 0, 0, 0));
      tab.push_back(mk(0, 4'b0111, 4'b1101, 16'h0917, 0, 0, 1, 4'b0010, 1, 4'h0, 0));
      tab.push_back(mk(0, 4'b0111, 4'b1101, 16'h0927, 0, 0, 1, 4'b0010, 1, 4'h1, 1));
      tab.push_back(mk(0, 4'b0111, 4'b1111, 16'h0937, 0, 0, 1, 4'b0010, 1, 4'h2, 1));
      tab.push_back(mk(0, 4'b0101, 4'b1111, 16'h0907, 0, 0, 1, 4'b0100, 1, 4'h3, 1));
      tab.push_back(mk(0, 4'b0101, 4'b1111, 16'h0907, 0, 0, 1, 4'b0001, 1, 4'h9, 2));
      tab.push_back(mk(0, 4'b0000, 4'b1111, 16'h0907, 0, 0, 1, 4'b0000, 1, 4'h7, 0));
      // Reset while locked on ch3 drops the lock; ch0 wins afterwards
      tab.push_back(mk(1, 4'h0, 4'hf, 16'h0000, 0, 0, 1, 4'b0000, 0, 0, 0));
      tab.push_back(mk(0, 4'b1000, 4'b0000, 16'h4000, 0, 0, 1, 4'b1000, 0, 0, 0));
      tab.push_back(mk(0, 4'b1001, 4'b0000, 16'h5006, 0, 0, 1, 4'b1000, 1, 4'h4, 3));
      tab.push_back(mk(1, 4'b1001, 4'b0000, 16'h5006, 0, 0, 1, 4'b0000, 0, 0, 0));
      tab.push_back(mk(0, 4'b1001, 4'b1111, 16'h7006, 0, 0, 1, 4'b0001, 0, 0, 0));
      tab.push_back(mk(0, 4'b0000, 4'b1111, 16'h7006, 0, 0, 1, 4'b0000, 1, 4'h6, 0));

      for (int i = 0; i < tab.size(); i++) begin
         run(tab[i], 1'b1, $sformatf("tab%0d", i));
         if (i == 0) begin
            check("reset out_valid", 32'(out_valid), 32'd0);
            check("reset out_data", 32'(out_data), 32'd0);
            check("reset out_last", 32'(out_last), 32'd0);
            check("reset out_ch", 32'(out_ch), 32'd0);
         end
      end

      // Backpressure: beat 5 held for three cycles, then traffic resumes
      run(mk(1, 4'h0, 4'hf, 16'h0000, 0, 0, 1, 0, 0, 0, 0), 1'b0, "hold_rst");
      run(mk(0, 4'b0001, 4'hf, 16'h0005, 0, 0, 1, 0, 0, 0, 0), 1'b0, "hold_load");
      for (int i = 0; i < 3; i++)
         run(mk(0, 4'hf, 4'hf, 16'hedc5, 0, 0, 0, 0, 0, 0, 0), 1'b0, $sformatf("hold%0d", i));
      check("hold out_data", 32'(out_data), 32'd5);
      run(mk(0, 4'hf, 4'hf, 16'hedc5, 0, 0, 1, 0, 0, 0, 0), 1'b0, "hold_rel");
      run(mk(0, 4'h0, 4'hf, 16'hedc5, 0, 0, 1, 0, 0, 0, 0), 1'b0, "hold_next");
      check("hold next beat", 32'(out_data), 32'hc);

      // Fixed select on ch2, then a fixed_sel change during a ch2 packet
      run(mk(1, 4'h0, 4'hf, 16'h0000, 1, 2, 1, 0, 0, 0, 0), 1'b0, "fix_rst");
      for (int i = 0; i < 4; i++)
         run(mk(0, 4'hf, 4'hf, 16'h4321, 1, 2, 1, 0, 0, 0, 0), 1'b0, $sformatf("fix%0d", i));
      run(mk(0, 4'hf, 4'b1011, 16'h4621, 1, 2, 1, 0, 0, 0, 0), 1'b0, "fix_pkt0");
      run(mk(0, 4'hf, 4'b1011, 16'h4721, 1, 0, 1, 0, 0, 0, 0), 1'b0, "fix_pkt1");
      run(mk(0, 4'hf, 4'b1111, 16'h4821, 1, 0, 1, 0, 0, 0, 0), 1'b0, "fix_pkt2");
      run(mk(0, 4'hf, 4'b1111, 16'h4321, 1, 0, 1, 0, 0, 0, 0), 1'b0, "fix_new");
      run(mk(0, 4'h0, 4'b1111, 16'h4321, 1, 0, 1, 0, 0, 0, 0), 1'b0, "fix_drain");
      check("fixed_sel after last", 32'(out_ch), 32'd0);

      // Idle gap leaves the round-robin pointer untouched
      run(mk(1, 4'h0, 4'hf, 16'h0000, 0, 0, 1, 0, 0, 0, 0), 1'b0, "idle_rst");
      run(mk(0, 4'b0011, 4'hf, 16'h00a9, 0, 0, 1, 0, 0, 0, 0), 1'b0, "idle_b0");
      for (int i = 0; i < 5; i++)
         run(mk(0, 4'h0, 4'hf, 16'h00a9, 0, 0, 1, 0, 0, 0, 0), 1'b0, $sformatf("idle%0d", i));
      run(mk(0, 4'b0011, 4'hf, 16'h00a9, 0, 0, 1, 0, 0, 0, 0), 1'b0, "idle_b1");
      run(mk(0, 4'h0, 4'hf, 16'h00a9, 0, 0, 1, 0, 0, 0, 0), 1'b0, "idle_b2");
      check("idle next grant", 32'(out_ch), 32'd1);

      // Random traffic with occasional resets, backpressure and mode flips
      for (int i = 0; i < 600; i++) begin
         v = mk(($urandom_range(0, 80) == 0), 4'($urandom), 4'($urandom | $urandom),
                16'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
                ($urandom_range(0, 3) != 0), 0, 0, 0, 0);
         run(v, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/stream_mux_n_1.md
STREAM_MUX_N_1 -- requirements
Module: stream_mux_n_1

Interface
REQ-001 Parameter: N, 4, number of input channels; SHALL be >= 2.
REQ-002 Parameter: WIDTH, 4, data bits per beat.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  N  per-channel beat valid.
REQ-006 Port: in_ready  output  N  per-channel accept; at most one bit high per cycle.
REQ-007 Port: in_data  input  N x WIDTH  packed array, channel i in element i.
REQ-008 Port: in_last  input  N  per-channel last beat of packet.
REQ-009 Port: fixed_mode  input  1  0 = round-robin arbitration, 1 = fixed select.
REQ-010 Port: fixed_sel  input  $clog2(N)  channel used when fixed_mode = 1.
REQ-011 Port: out_valid  output  1  registered beat valid.
REQ-012 Port: out_ready  input  1  downstream accept.
REQ-013 Port: out_data  output  WIDTH  registered data.
REQ-014 Port: out_last  output  1  registered last flag.
REQ-015 Port: out_ch  output  $clog2(N)  source channel of current output beat.

Function
REQ-016 Transfer on a channel SHALL occur when in_valid[i] and in_ready[i] are both high at a clock edge; same rule on output.
REQ-017 Output register SHALL accept a beat when out_valid = 0 or out_ready = 1 (full throughput, 1 beat/cycle).
REQ-018 Latency SHALL be exactly 1 cycle from input transfer to out_valid.
REQ-019 in_ready[g] SHALL be high only for granted channel g, only while the output register can accept; in_ready may depend combinationally on out_ready.
REQ-020 FSM states: IDLE (no packet open), LOCKED (packet open on channel g).
REQ-021 IDLE, round-robin: grant SHALL go to the first valid channel searching from ptr+1 upward modulo N.
REQ-022 IDLE, fixed mode: grant SHALL be fixed_sel; other channels SHALL stay not ready.
REQ-023 On a transfer in IDLE, ptr SHALL update to the granted channel; if in_last = 0 then FSM -> LOCKED on that channel.
REQ-024 LOCKED: grant SHALL stay on locked channel regardless of other valids, fixed_mode or fixed_sel; transfer with in_last = 1 SHALL return FSM to IDLE.
REQ-025 Changes on fixed_mode/fixed_sel SHALL take effect only at the next IDLE arbitration.
REQ-026 No valid input in IDLE: no grant, ptr unchanged, FSM stays IDLE.
REQ-027 Output held (out_valid = 1, out_ready = 0): out_data/out_last/out_ch SHALL remain stable, all in_ready low.
REQ-028 Single-beat packet (in_last = 1 on first beat) SHALL not enter LOCKED.
REQ-029 Beats from one packet SHALL never interleave with another channel at the output.

Reset
REQ-030 On rst: out_valid = 0, out_data = 0, out_last = 0, out_ch = 0, FSM = IDLE, ptr = N-1 (channel 0 first priority).
REQ-031 rst mid-packet SHALL drop the lock and discard any held output beat; in_ready SHALL be all low during the rst cycle.

Structure
REQ-032 Package stream_mux_pkg SHALL hold the FSM state enum typedef.
REQ-033 One sub-module rr_arbiter (N, valids, ptr -> one-hot grant + index, combinational) SHALL implement the round-robin search.

Verification (N = 4, WIDTH = 4)
REQ-034 After reset, all valids high, out_ready = 1, last = 1 everywhere, data i = 'ha+i -> out_data sequence a, b, c, d, a; out_ch 0,1,2,3,0.
REQ-035 Ch1 sends 3-beat packet 1,2,3 (last on 3) while ch0/ch2 valid -> output 1,2,3 from ch1 contiguous, then ch2 granted.
REQ-036 out_ready = 0 for 3 cycles with beat 'h5 held -> out_data stays 5, all in_ready low; release -> next beat follows in 1 cycle.
REQ-037 fixed_mode = 1, fixed_sel = 2, all valid -> only ch2 ready, out_ch = 2 every beat; fixed_sel changed mid-packet -> takes effect after last.
REQ-038 rst asserted during LOCKED on ch3 -> next cycle out_valid = 0, IDLE, ch0 wins next arbitration.
REQ-039 No valids for 5 cycles -> out_valid 0 once drained, ptr unchanged (next grant order unaffected).
